// File: rtl/run_sequencer.sv
// Run controller for the 9-bit core: req/done handshake, host preload vs core write arbitration, cycle budget.
// Latency: state outputs (done, timeout, core_rst, host_ready, cycle_cnt) are registered, one cycle after the deciding edge; memory port mux is combinational.
// Backpressure: host beats are accepted only while host_ready=1 (LOAD); host beats outside LOAD and core writes outside RUN are dropped.
//
// Ports:
//   clk, reset        clock and asynchronous active-low reset
//   req / done        start/hold request in, run-finished flag out; timeout qualifies done
//   core_rst          holds the core's PC/registers while not running
//   prog_ctr          core PC, compared against END_PC to detect completion
//   host_*            preload beat port (valid/last/addr/din in, ready out)
//   core_wr_en/addr/din  core store port, forwarded only during RUN
//   mem_wr_en/addr/din   arbitrated data-memory write port
//   cycle_cnt         RUN cycles of the current/last run, saturating

module run_sequencer #(
  parameter int D       = 12,
  parameter int END_PC  = 500,
  parameter int CW      = 16,
  parameter int MAX_CYC = 65535
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req,
  output logic          done,
  output logic          timeout,
  output logic          core_rst,
  input  logic [D-1:0]  prog_ctr,
  input  logic          host_valid,
  input  logic          host_last,
  input  logic [7:0]    host_addr,
  input  logic [7:0]    host_din,
  output logic          host_ready,
  input  logic          core_wr_en,
  input  logic [7:0]    core_addr,
  input  logic [7:0]    core_din,
  output logic          mem_wr_en,
  output logic [7:0]    mem_addr,
  output logic [7:0]    mem_din,
  output logic [CW-1:0] cycle_cnt
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_RUN  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam logic [D-1:0]  END_PC_V   = D'(END_PC);
  localparam logic [CW-1:0] CYC_MAX_V  = CW'(MAX_CYC);
  localparam logic [CW-1:0] CYC_LAST_V = CW'(MAX_CYC - 1);

  state_t        state_q, state_d;
  logic          done_q, done_d;
  logic          timeout_q, timeout_d;
  logic          core_rst_q, core_rst_d;
  logic          host_ready_q, host_ready_d;
  logic [CW-1:0] cycle_cnt_q, cycle_cnt_d;

  logic host_fire;
  logic at_end_pc;
  logic at_budget;

  // host_ready_q is only ever set while in LOAD, so this is a LOAD-only transfer.
  assign host_fire = host_valid & host_ready_q;
  assign at_end_pc = (prog_ctr == END_PC_V);
  // The count still holds the previous cycle's value, so LAST means this cycle
  // is the final one the budget allows.
  assign at_budget = (cycle_cnt_q == CYC_LAST_V);

  // Next-state and next-output logic; outputs are decided together with the
  // transition so they land in their registers on the same edge.
  always_comb begin
    state_d      = state_q;
    done_d       = done_q;
    timeout_d    = timeout_q;
    core_rst_d   = core_rst_q;
    host_ready_d = host_ready_q;
    cycle_cnt_d  = cycle_cnt_q;

    case (state_q)
      S_IDLE: begin
        done_d       = 1'b0;
        core_rst_d   = 1'b1;
        host_ready_d = 1'b0;
        if (req) begin
          state_d      = S_LOAD;
          cycle_cnt_d  = '0;
          timeout_d    = 1'b0;
          host_ready_d = 1'b1;
        end
      end

      S_LOAD: begin
        // Abort takes priority over a final beat; the beat itself is still
        // written because the memory mux looks only at the current state.
        if (!req) begin
          state_d      = S_IDLE;
          host_ready_d = 1'b0;
        end else if (host_fire && host_last) begin
          state_d      = S_RUN;
          host_ready_d = 1'b0;
          core_rst_d   = 1'b0;
        end
      end

      S_RUN: begin
        if (cycle_cnt_q != CYC_MAX_V) begin
          cycle_cnt_d = cycle_cnt_q + CW'(1);
        end
        // End-of-program beats the budget when both land in one cycle.
        if (at_end_pc) begin
          state_d    = S_DONE;
          timeout_d  = 1'b0;
          done_d     = 1'b1;
          core_rst_d = 1'b1;
        end else if (at_budget) begin
          state_d    = S_DONE;
          timeout_d  = 1'b1;
          done_d     = 1'b1;
          core_rst_d = 1'b1;
        end
      end

      S_DONE: begin
        if (!req) begin
          state_d = S_IDLE;
          done_d  = 1'b0;
        end
      end

      default: begin
        state_d      = S_IDLE;
        done_d       = 1'b0;
        core_rst_d   = 1'b1;
        host_ready_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      done_q       <= 1'b0;
      timeout_q    <= 1'b0;
      core_rst_q   <= 1'b1;
      host_ready_q <= 1'b0;
      cycle_cnt_q  <= '0;
    end else begin
      state_q      <= state_d;
      done_q       <= done_d;
      timeout_q    <= timeout_d;
      core_rst_q   <= core_rst_d;
      host_ready_q <= host_ready_d;
      cycle_cnt_q  <= cycle_cnt_d;
    end
  end

  // Data-memory write port. Outside LOAD the address follows the core so reads
  // can be inspected while idle or done; only RUN lets core writes through.
  always_comb begin
    mem_wr_en = 1'b0;
    mem_addr  = core_addr;
    mem_din   = core_din;
    case (state_q)
      S_LOAD: begin
        mem_wr_en = host_fire;
        mem_addr  = host_addr;
        mem_din   = host_din;
      end
      S_RUN: begin
        mem_wr_en = core_wr_en;
      end
      default: begin
        mem_wr_en = 1'b0;
      end
    endcase
  end

  assign done       = done_q;
  assign timeout    = timeout_q;
  assign core_rst   = core_rst_q;
  assign host_ready = host_ready_q;
  assign cycle_cnt  = cycle_cnt_q;

endmodule

// File: tb/tb_run_sequencer.sv
// Bench for run_sequencer: directed run sequences, a table of arbitration vectors
// applied in every state, and a queue of expected memory writes popped by a monitor.
// Uses MAX_CYC=100 so the timeout paths are reachable quickly.

module tb_run_sequencer;

  localparam int D       = 12;
  localparam int CW      = 16;
  localparam int MAX_CYC = 100;

  logic          clk = 1'b0;
  logic          reset;
  logic          req;
  logic          done;
  logic          timeout;
  logic          core_rst;
  logic [D-1:0]  prog_ctr;
  logic          host_valid;
  logic          host_last;
  logic [7:0]    host_addr;
  logic [7:0]    host_din;
  logic          host_ready;
  logic          core_wr_en;
  logic [7:0]    core_addr;
  logic [7:0]    core_din;
  logic          mem_wr_en;
  logic [7:0]    mem_addr;
  logic [7:0]    mem_din;
  logic [CW-1:0] cycle_cnt;

  run_sequencer #(
    .D(D), .END_PC(500), .CW(CW), .MAX_CYC(MAX_CYC)
  ) dut (
    .clk(clk), .reset(reset), .req(req), .done(done), .timeout(timeout),
    .core_rst(core_rst), .prog_ctr(prog_ctr), .host_valid(host_valid),
    .host_last(host_last), .host_addr(host_addr), .host_din(host_din),
    .host_ready(host_ready), .core_wr_en(core_wr_en), .core_addr(core_addr),
    .core_din(core_din), .mem_wr_en(mem_wr_en), .mem_addr(mem_addr),
    .mem_din(mem_din), .cycle_cnt(cycle_cnt)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int wr_seen  = 0;
  logic [15:0] exp_q[$];

  typedef struct {
    logic [1:0] ph;      // 0 IDLE, 1 LOAD, 2 RUN, 3 DONE
    logic       hv;
    logic       cw;
    logic [7:0] ha;
    logic [7:0] hd;
    logic [7:0] ca;
    logic [7:0] cd;
    logic       exp_en;
    logic [7:0] exp_addr;
    logic [7:0] exp_din;
  } vec_t;

  localparam int NV = 10;
  vec_t vt [NV];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Write monitor: every memory write must match the oldest expected write.
  initial begin
    logic [15:0] e;
    forever begin
      @(negedge clk);
      #3;
      if (mem_wr_en === 1'b1) begin
        wr_seen++;
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL mem_write_unexpected actual=%0h required=none t=%0t",
                   {mem_addr, mem_din}, $time);
        end else begin
          e = exp_q.pop_front();
          chk("mem_write", 32'({mem_addr, mem_din}), 32'(e));
        end
      end
    end
  end

  task automatic idle_inputs();
    host_valid = 1'b0;
    host_last  = 1'b0;
    core_wr_en = 1'b0;
    prog_ctr   = '0;
  endtask

  task automatic quiet();
    @(negedge clk);
    idle_inputs();
  endtask

  task automatic start_load();
    @(negedge clk);
    idle_inputs();
    req = 1'b1;
  endtask

  task automatic beat(input logic [7:0] a, input logic [7:0] d, input logic last);
    @(negedge clk);
    idle_inputs();
    host_valid = 1'b1;
    host_addr  = a;
    host_din   = d;
    host_last  = last;
    exp_q.push_back({a, d});
  endtask

  task automatic apply_phase(input logic [1:0] ph);
    for (int i = 0; i < NV; i++) begin
      if (vt[i].ph == ph) begin
        @(negedge clk);
        idle_inputs();
        host_valid = vt[i].hv;
        core_wr_en = vt[i].cw;
        host_addr  = vt[i].ha;
        host_din   = vt[i].hd;
        core_addr  = vt[i].ca;
        core_din   = vt[i].cd;
        if (vt[i].exp_en) exp_q.push_back({vt[i].exp_addr, vt[i].exp_din});
        #1;
        chk($sformatf("vec%0d_wr_en", i), 32'(mem_wr_en), 32'(vt[i].exp_en));
        chk($sformatf("vec%0d_addr", i),  32'(mem_addr),  32'(vt[i].exp_addr));
        chk($sformatf("vec%0d_din", i),   32'(mem_din),   32'(vt[i].exp_din));
      end
    end
  endtask

  initial begin
    int base;

    //            ph     hv    cw    ha     hd     ca     cd     en    eaddr  edin
    vt[0] = '{2'd0, 1'b0, 1'b1, 8'h10, 8'h20, 8'h30, 8'h40, 1'b0, 8'h30, 8'h40};
    vt[1] = '{2'd0, 1'b1, 1'b1, 8'h11, 8'h21, 8'h31, 8'h41, 1'b0, 8'h31, 8'h41};
    vt[2] = '{2'd1, 1'b1, 1'b1, 8'h50, 8'h51, 8'h52, 8'h53, 1'b1, 8'h50, 8'h51};
    vt[3] = '{2'd1, 1'b0, 1'b1, 8'h54, 8'h55, 8'h56, 8'h57, 1'b0, 8'h54, 8'h55};
    vt[4] = '{2'd1, 1'b1, 1'b0, 8'h58, 8'h59, 8'h5a, 8'h5b, 1'b1, 8'h58, 8'h59};
    vt[5] = '{2'd2, 1'b1, 1'b0, 8'h60, 8'h61, 8'h62, 8'h63, 1'b0, 8'h62, 8'h63};
    vt[6] = '{2'd2, 1'b1, 1'b1, 8'h64, 8'h65, 8'h66, 8'h67, 1'b1, 8'h66, 8'h67};
    vt[7] = '{2'd2, 1'b0, 1'b1, 8'h68, 8'h69, 8'h6a, 8'h6b, 1'b1, 8'h6a, 8'h6b};
    vt[8] = '{2'd3, 1'b1, 1'b1, 8'h70, 8'h71, 8'h72, 8'h73, 1'b0, 8'h72, 8'h73};
    vt[9] = '{2'd3, 1'b0, 1'b1, 8'h74, 8'h75, 8'h76, 8'h77, 1'b0, 8'h76, 8'h77};

    reset = 1'b0;
    req   = 1'b0;
    host_addr = '0; host_din = '0; core_addr = '0; core_din = '0;
    idle_inputs();

    // Reset state
    @(negedge clk); @(negedge clk); #1;
    chk("rst_done",       32'(done),       0);
    chk("rst_timeout",    32'(timeout),    0);
    chk("rst_core_rst",   32'(core_rst),   1);
    chk("rst_host_ready", 32'(host_ready), 0);
    chk("rst_cycle_cnt",  32'(cycle_cnt),  0);
    chk("rst_mem_wr_en",  32'(mem_wr_en),  0);
    reset = 1'b1;
    quiet();

    // Preload three beats, end-of-program at RUN cycle 40
    base = wr_seen;
    start_load();
    beat(8'ha0, 8'h11, 1'b0);
    #1 chk("t1_host_ready_load", 32'(host_ready), 1);
    beat(8'ha1, 8'h22, 1'b0);
    beat(8'ha2, 8'h33, 1'b1);
    for (int k = 1; k <= 40; k++) begin
      quiet();
      if (k == 1) begin
        #1;
        chk("t1_run_core_rst",   32'(core_rst),   0);
        chk("t1_run_host_ready", 32'(host_ready), 0);
        chk("t1_run_cnt_start",  32'(cycle_cnt),  0);
      end
      if (k == 40) prog_ctr = 12'd500;
    end
    quiet();
    #1;
    chk("t1_done",     32'(done),         1);
    chk("t1_timeout",  32'(timeout),      0);
    chk("t1_cnt",      32'(cycle_cnt),    40);
    chk("t1_core_rst", 32'(core_rst),     1);
    chk("t1_writes",   32'(wr_seen - base), 3);

    // DONE held by req
    for (int k = 0; k < 5; k++) begin
      quiet();
      #1 chk("t7_done_hold", 32'(done), 1);
    end
    chk("t7_cnt_frozen", 32'(cycle_cnt), 40);
    quiet();
    req = 1'b0;
    #1 chk("t7_done_before_edge", 32'(done), 1);
    quiet();
    #1;
    chk("t7_done_fall",  32'(done),       0);
    chk("t7_idle_ready", 32'(host_ready), 0);
    chk("t7_idle_crst",  32'(core_rst),   1);

    // Cycle-budget timeout
    start_load();
    beat(8'hb0, 8'h01, 1'b1);
    for (int k = 1; k <= 100; k++) begin
      quiet();
      if (k == 100) begin
        #1;
        chk("t2_cnt_before_budget",  32'(cycle_cnt), 99);
        chk("t2_done_before_budget", 32'(done),      0);
      end
    end
    quiet();
    #1;
    chk("t2_done",     32'(done),      1);
    chk("t2_timeout",  32'(timeout),   1);
    chk("t2_cnt",      32'(cycle_cnt), 100);
    chk("t2_core_rst", 32'(core_rst),  1);
    req = 1'b0;
    quiet();

    // End-of-program and budget in the same cycle
    start_load();
    beat(8'hb1, 8'h02, 1'b1);
    #1;
    chk("t3_cnt_cleared",     32'(cycle_cnt), 0);
    chk("t3_timeout_cleared", 32'(timeout),   0);
    for (int k = 1; k <= 100; k++) begin
      quiet();
      if (k == 100) prog_ctr = 12'd500;
    end
    quiet();
    #1;
    chk("t3_done",    32'(done),      1);
    chk("t3_timeout", 32'(timeout),   0);
    chk("t3_cnt",     32'(cycle_cnt), 100);
    req = 1'b0;
    quiet();

    // Abort mid-LOAD, beat in the abort cycle still written
    start_load();
    beat(8'hc0, 8'h44, 1'b0);
    beat(8'hc1, 8'h55, 1'b0);
    beat(8'hc2, 8'h66, 1'b0);
    req = 1'b0;
    #1 chk("t5_abort_beat_wr", 32'(mem_wr_en), 1);
    quiet();
    #1;
    chk("t5_ready_drop", 32'(host_ready), 0);
    chk("t5_core_rst",   32'(core_rst),   1);
    chk("t5_done",       32'(done),       0);
    quiet();
    req = 1'b1;
    quiet();
    #1;
    chk("t5_reload_ready", 32'(host_ready), 1);
    chk("t5_reload_cnt",   32'(cycle_cnt),  0);
    req = 1'b0;
    quiet();

    // Arbitration table across IDLE, LOAD, RUN, DONE
    apply_phase(2'd0);
    quiet();
    req = 1'b1;
    apply_phase(2'd1);
    beat(8'h7f, 8'h7e, 1'b1);
    apply_phase(2'd2);
    quiet();
    prog_ctr = 12'd500;
    apply_phase(2'd3);
    #1 chk("t4_in_done", 32'(done), 1);
    quiet();
    req = 1'b0;
    quiet();

    // Asynchronous reset mid-RUN
    start_load();
    beat(8'hd0, 8'h01, 1'b1);
    for (int k = 1; k <= 9; k++) quiet();
    quiet();
    #1 chk("t6_cnt_before_reset", 32'(cycle_cnt), 9);
    #1 reset = 1'b0;
    #1;
    chk("t6_async_core_rst", 32'(core_rst),   1);
    chk("t6_async_done",     32'(done),       0);
    chk("t6_async_cnt",      32'(cycle_cnt),  0);
    chk("t6_async_ready",    32'(host_ready), 0);
    quiet();
    #1 chk("t6_held_ready", 32'(host_ready), 0);
    reset = 1'b1;
    quiet();
    #1 chk("t6_load_after_release", 32'(host_ready), 1);
    req = 1'b0;
    quiet();
    quiet();

    chk("sb_empty", 32'(exp_q.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
